// File: rtl/mem_access_responder_if.sv
// Request/response and memory-strobe bundle of the memory access responder.
// The responder uses the slave modport. The master modport is for the requester,
// which also plays the memory and so drives the read-data input.
interface mem_access_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mdata_in;
  logic              busy;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ma;
  logic [DATA_W-1:0] md_out;
  logic              moe;
  logic              mwe;

  modport slave (
    input  req, wr, addr, wdata, mdata_in,
    output busy, ack, err, rdata, ma, md_out, moe, mwe
  );

  modport master (
    output req, wr, addr, wdata, mdata_in,
    input  busy, ack, err, rdata, ma, md_out, moe, mwe
  );
endinterface

// File: rtl/mem_access_responder.sv
// Memory-side responder. It accepts one read or write at a time and drives the
// memory strobes through SETUP and a programmable number of WAIT cycles. It then
// pulses ACK for one cycle (with ERR for a rejected misaligned request).
// Every output is a register with an asynchronous reset. A reset in the middle
// of a transaction therefore drops MOE/MWE at once and no ACK is issued.
module mem_access_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_access_responder_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // The counter reload value is only used when at least one wait state exists.
  localparam logic [3:0] WAIT_LOAD_C = 4'(WAIT_CYCLES - 1);
  localparam bit         HAS_WAIT_C  = (WAIT_CYCLES != 32'sd0);
  localparam bit         ALIGN_ON_C  = (CHECK_ALIGN != 32'sd0);

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic              wr_r;
  logic              busy_r;
  logic              ack_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] ma_r;
  logic [DATA_W-1:0] md_out_r;
  logic              moe_r;
  logic              mwe_r;
  logic              misaligned_s;

  // Flag a request whose address is not word aligned, when the check is enabled.
  always_comb begin
    misaligned_s = 1'b0;
    if (ALIGN_ON_C) begin
      misaligned_s = (bus.addr[1:0] != 2'b00);
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Transaction sequencer. Each output register is loaded on the edge that
  // enters the state where it must be valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      wr_r     <= 1'b0;
      busy_r   <= 1'b0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= {DATA_W{1'b0}};
      ma_r     <= {ADDR_W{1'b0}};
      md_out_r <= {DATA_W{1'b0}};
      moe_r    <= 1'b0;
      mwe_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req) begin
            wr_r   <= bus.wr;
            busy_r <= 1'b1;
            if (misaligned_s) begin
              // Rejected at once: no strobes, MA left untouched.
              state_r <= ST_DONE;
              ack_r   <= 1'b1;
              err_r   <= 1'b1;
            end else begin
              state_r <= ST_SETUP;
              ma_r    <= bus.addr;
              if (bus.wr) begin
                md_out_r <= bus.wdata;
                // Without wait states, SETUP must carry the single write strobe.
                mwe_r    <= !HAS_WAIT_C;
              end else begin
                moe_r <= 1'b1;
              end
            end
          end
        end
        ST_SETUP: begin
          if (HAS_WAIT_C) begin
            state_r <= ST_WAIT;
            cnt_r   <= WAIT_LOAD_C;
            mwe_r   <= wr_r;
          end else begin
            state_r <= ST_DONE;
            ack_r   <= 1'b1;
            moe_r   <= 1'b0;
            mwe_r   <= 1'b0;
            if (!wr_r) begin
              rdata_r <= bus.mdata_in;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_DONE;
            ack_r   <= 1'b1;
            moe_r   <= 1'b0;
            mwe_r   <= 1'b0;
            if (!wr_r) begin
              rdata_r <= bus.mdata_in;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          moe_r   <= 1'b0;
          mwe_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.ack    = ack_r;
  assign bus.err    = err_r;
  assign bus.rdata  = rdata_r;
  assign bus.ma     = ma_r;
  assign bus.md_out = md_out_r;
  assign bus.moe    = moe_r;
  assign bus.mwe    = mwe_r;

endmodule

// File: tb/tb_mem_access_responder.sv
// Self-checking bench for mem_access_responder. It has one instance with two
// wait states and one with none. Expected ACK results go into a queue when a
// request is driven and are compared when the DUT acknowledges.
module tb_mem_access_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [31:0] last_rdata;

  mem_access_responder_if #(.ADDR_W(16), .DATA_W(32)) if_w2 ();
  mem_access_responder_if #(.ADDR_W(16), .DATA_W(32)) if_w0 ();

  mem_access_responder #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(2), .CHECK_ALIGN(1)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .bus(if_w2)
  );
  mem_access_responder #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(0), .CHECK_ALIGN(1)) dut_w0 (
    .clk(clk), .rst_n(rst_n), .bus(if_w0)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit in case something stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drive one request into the W=2 instance and observe it until ACK or timeout.
  task automatic run_w2(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mdata, output int ack_cyc, output int moe_cnt,
                        output int mwe_cnt, output logic err_ack, output logic [31:0] rdata_ack,
                        output logic [15:0] ma_first, output logic [31:0] md_first,
                        output logic ma_held, output logic err_stray);
    ack_cyc = -1; moe_cnt = 0; mwe_cnt = 0; err_ack = 1'b0; rdata_ack = 32'h0;
    ma_first = 16'h0; md_first = 32'h0; ma_held = 1'b1; err_stray = 1'b0;
    if_w2.req = 1'b1; if_w2.wr = wr; if_w2.addr = addr; if_w2.wdata = wdata;
    if_w2.mdata_in = mdata;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ma_first = if_w2.ma;
        md_first = if_w2.md_out;
        // Drop REQ and scramble the request fields: the DUT must ignore them now.
        if_w2.req = 1'b0; if_w2.addr = 16'hFFFF; if_w2.wdata = 32'h0; if_w2.wr = ~wr;
      end else if (if_w2.ma !== ma_first) begin
        ma_held = 1'b0;
      end
      if (if_w2.moe === 1'b1) moe_cnt++;
      if (if_w2.mwe === 1'b1) mwe_cnt++;
      if (if_w2.err === 1'b1 && if_w2.ack !== 1'b1) err_stray = 1'b1;
      if (if_w2.ack === 1'b1) begin
        ack_cyc = c; err_ack = if_w2.err; rdata_ack = if_w2.rdata;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [84:0] obs;
    logic        stray;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {if_w2.busy, if_w2.ack, if_w2.err, if_w2.rdata, if_w2.ma, if_w2.md_out, if_w2.moe, if_w2.mwe};
    checks++;
    if (obs !== 85'd0) begin errors++; $display("FAIL reset_w2_outputs: got %h expected 0", obs); end
    obs = {if_w0.busy, if_w0.ack, if_w0.err, if_w0.rdata, if_w0.ma, if_w0.md_out, if_w0.moe, if_w0.mwe};
    checks++;
    if (obs !== 85'd0) begin errors++; $display("FAIL reset_w0_outputs: got %h expected 0", obs); end
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_w2.ack !== 1'b0 || if_w2.busy !== 1'b0 || if_w0.ack !== 1'b0 || if_w0.busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL idle_no_ack: got activity=%b expected 0", stray); end
    obs = {if_w2.busy, if_w2.ack, if_w2.err, if_w2.rdata, if_w2.ma, if_w2.md_out, if_w2.moe, if_w2.mwe};
    checks++;
    if (obs !== 85'd0) begin errors++; $display("FAIL idle_outputs: got %h expected 0", obs); end
    last_rdata = 32'h0;
  endtask

  task automatic test_read_w2;
    int ack_cyc, moe_cnt, mwe_cnt;
    logic err_ack, ma_held, err_stray;
    logic [31:0] rdata_ack, md_first;
    logic [15:0] ma_first;
    exp_t e;
    sb_q.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
    last_rdata = 32'hDEADBEEF;
    run_w2(1'b0, 16'h0040, 32'h0, 32'hDEADBEEF, ack_cyc, moe_cnt, mwe_cnt, err_ack, rdata_ack,
           ma_first, md_first, ma_held, err_stray);
    checks++;
    if (ack_cyc !== 4) begin errors++; $display("FAIL read_ack_cycle: got %0d expected 4", ack_cyc); end
    checks++;
    if (moe_cnt !== 3) begin errors++; $display("FAIL read_moe_cycles: got %0d expected 3", moe_cnt); end
    checks++;
    if (mwe_cnt !== 0) begin errors++; $display("FAIL read_mwe_cycles: got %0d expected 0", mwe_cnt); end
    checks++;
    if (ma_first !== 16'h0040 || ma_held !== 1'b1) begin
      errors++; $display("FAIL read_ma: got %h held=%b expected 0040 held=1", ma_first, ma_held);
    end
    checks++;
    if (err_stray !== 1'b0) begin errors++; $display("FAIL read_err_without_ack: got 1 expected 0"); end
    if (ack_cyc > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({err_ack, rdata_ack} !== {e.err, e.rdata}) begin
        errors++; $display("FAIL read_result: got err=%b rdata=%h expected err=%b rdata=%h", err_ack, rdata_ack, e.err, e.rdata);
      end
    end else begin
      checks++; errors++; $display("FAIL read_timeout: got no ACK expected ACK");
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_write_w2;
    int ack_cyc, moe_cnt, mwe_cnt;
    logic err_ack, ma_held, err_stray;
    logic [31:0] rdata_ack, md_first;
    logic [15:0] ma_first;
    exp_t e;
    sb_q.push_back('{err: 1'b0, rdata: last_rdata});
    run_w2(1'b1, 16'h0104, 32'h12345678, 32'h0BADF00D, ack_cyc, moe_cnt, mwe_cnt, err_ack, rdata_ack,
           ma_first, md_first, ma_held, err_stray);
    checks++;
    if (ack_cyc !== 4) begin errors++; $display("FAIL write_ack_cycle: got %0d expected 4", ack_cyc); end
    checks++;
    if (mwe_cnt !== 2) begin errors++; $display("FAIL write_mwe_cycles: got %0d expected 2", mwe_cnt); end
    checks++;
    if (moe_cnt !== 0) begin errors++; $display("FAIL write_moe_cycles: got %0d expected 0", moe_cnt); end
    checks++;
    if (md_first !== 32'h12345678) begin errors++; $display("FAIL write_md_setup: got %h expected 12345678", md_first); end
    checks++;
    if (ma_first !== 16'h0104 || ma_held !== 1'b1) begin
      errors++; $display("FAIL write_ma: got %h held=%b expected 0104 held=1", ma_first, ma_held);
    end
    if (ack_cyc > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({err_ack, rdata_ack} !== {e.err, e.rdata}) begin
        errors++; $display("FAIL write_result: got err=%b rdata=%h expected err=%b rdata=%h", err_ack, rdata_ack, e.err, e.rdata);
      end
    end else begin
      checks++; errors++; $display("FAIL write_timeout: got no ACK expected ACK");
      sb_q.delete();
    end
    @(negedge clk);
    checks++;
    if (if_w2.md_out !== 32'h12345678 || if_w2.ma !== 16'h0104 || if_w2.busy !== 1'b0) begin
      errors++; $display("FAIL write_idle_hold: got md=%h ma=%h busy=%b expected 12345678 0104 0", if_w2.md_out, if_w2.ma, if_w2.busy);
    end
  endtask

  task automatic test_misaligned;
    int ack_cyc, moe_cnt, mwe_cnt;
    logic err_ack, ma_held, err_stray;
    logic [31:0] rdata_ack, md_first;
    logic [15:0] ma_first, ma_before;
    exp_t e;
    ma_before = 16'h0104;
    sb_q.push_back('{err: 1'b1, rdata: last_rdata});
    run_w2(1'b0, 16'h0042, 32'h0, 32'h77777777, ack_cyc, moe_cnt, mwe_cnt, err_ack, rdata_ack,
           ma_first, md_first, ma_held, err_stray);
    checks++;
    if (ack_cyc !== 1) begin errors++; $display("FAIL misaligned_ack_cycle: got %0d expected 1", ack_cyc); end
    checks++;
    if (moe_cnt !== 0 || mwe_cnt !== 0) begin
      errors++; $display("FAIL misaligned_strobes: got moe=%0d mwe=%0d expected 0 0", moe_cnt, mwe_cnt);
    end
    if (ack_cyc > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({err_ack, rdata_ack} !== {e.err, e.rdata}) begin
        errors++; $display("FAIL misaligned_result: got err=%b rdata=%h expected err=%b rdata=%h", err_ack, rdata_ack, e.err, e.rdata);
      end
    end else begin
      checks++; errors++; $display("FAIL misaligned_timeout: got no ACK expected ACK");
      sb_q.delete();
    end
    @(negedge clk);
    checks++;
    if (if_w2.ma !== ma_before || if_w2.err !== 1'b0 || if_w2.ack !== 1'b0) begin
      errors++; $display("FAIL misaligned_after: got ma=%h err=%b ack=%b expected %h 0 0", if_w2.ma, if_w2.err, if_w2.ack, ma_before);
    end
  endtask

  task automatic test_back_to_back_w0;
    int acks, mwe_cnt, wack;
    int ack_c[2];
    logic busy_at3;
    exp_t e;
    acks = 0; ack_c[0] = -1; ack_c[1] = -1; busy_at3 = 1'b1;
    sb_q.push_back('{err: 1'b0, rdata: 32'h00000011});
    sb_q.push_back('{err: 1'b0, rdata: 32'h00000022});
    if_w0.req = 1'b1; if_w0.wr = 1'b0; if_w0.addr = 16'h0008; if_w0.wdata = 32'h0;
    if_w0.mdata_in = 32'h00000011;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin busy_at3 = if_w0.busy; if_w0.mdata_in = 32'h00000022; end
      if (c == 4) if_w0.req = 1'b0;
      if (if_w0.ack === 1'b1) begin
        if (acks < 2) ack_c[acks] = c;
        acks++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++;
          if ({if_w0.err, if_w0.rdata} !== {e.err, e.rdata}) begin
            errors++; $display("FAIL w0_read_result: got err=%b rdata=%h expected err=%b rdata=%h", if_w0.err, if_w0.rdata, e.err, e.rdata);
          end
        end
      end
      if (acks >= 2) break;
    end
    if_w0.req = 1'b0;
    checks++;
    if (ack_c[0] !== 2) begin errors++; $display("FAIL w0_first_ack_cycle: got %0d expected 2", ack_c[0]); end
    checks++;
    if (busy_at3 !== 1'b0) begin errors++; $display("FAIL w0_idle_gap: got busy=%b expected 0", busy_at3); end
    checks++;
    if (ack_c[1] !== 5) begin errors++; $display("FAIL w0_held_req_ack_cycle: got %0d expected 5", ack_c[1]); end
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (if_w0.busy !== 1'b0) begin errors++; $display("FAIL w0_no_third_txn: got busy=%b expected 0", if_w0.busy); end

    // Zero-wait write: the write strobe lives in SETUP.
    mwe_cnt = 0; wack = -1;
    if_w0.req = 1'b1; if_w0.wr = 1'b1; if_w0.addr = 16'h000C; if_w0.wdata = 32'hCAFEF00D;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) if_w0.req = 1'b0;
      if (if_w0.mwe === 1'b1) mwe_cnt++;
      if (if_w0.ack === 1'b1) begin wack = c; break; end
    end
    checks++;
    if (mwe_cnt !== 1 || wack !== 2) begin
      errors++; $display("FAIL w0_write: got mwe_cycles=%0d ack_cycle=%0d expected 1 2", mwe_cnt, wack);
    end
    checks++;
    if (if_w0.rdata !== 32'h00000022 || if_w0.md_out !== 32'hCAFEF00D) begin
      errors++; $display("FAIL w0_write_data: got rdata=%h md=%h expected 00000022 cafef00d", if_w0.rdata, if_w0.md_out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    int ack_cyc, moe_cnt, mwe_cnt;
    logic err_ack, ma_held, err_stray, stray;
    logic [31:0] rdata_ack, md_first;
    logic [15:0] ma_first;
    exp_t e;
    if_w2.req = 1'b1; if_w2.wr = 1'b1; if_w2.addr = 16'h0200; if_w2.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    if_w2.req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_w2.mwe !== 1'b1) begin errors++; $display("FAIL abort_mwe_before: got %b expected 1", if_w2.mwe); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if_w2.mwe !== 1'b0 || if_w2.moe !== 1'b0 || if_w2.busy !== 1'b0) begin
      errors++; $display("FAIL abort_async_drop: got mwe=%b moe=%b busy=%b expected 0 0 0", if_w2.mwe, if_w2.moe, if_w2.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    stray = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (if_w2.ack !== 1'b0 || if_w2.busy !== 1'b0 || if_w2.mwe !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got activity=%b expected 0", stray); end
    sb_q.push_back('{err: 1'b0, rdata: 32'h5A5A5A5A});
    last_rdata = 32'h5A5A5A5A;
    run_w2(1'b0, 16'h0300, 32'h0, 32'h5A5A5A5A, ack_cyc, moe_cnt, mwe_cnt, err_ack, rdata_ack,
           ma_first, md_first, ma_held, err_stray);
    checks++;
    if (ack_cyc !== 4 || moe_cnt !== 3) begin
      errors++; $display("FAIL post_abort_read_timing: got ack=%0d moe=%0d expected 4 3", ack_cyc, moe_cnt);
    end
    if (ack_cyc > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({err_ack, rdata_ack} !== {e.err, e.rdata}) begin
        errors++; $display("FAIL post_abort_read_result: got err=%b rdata=%h expected err=%b rdata=%h", err_ack, rdata_ack, e.err, e.rdata);
      end
    end else begin
      checks++; errors++; $display("FAIL post_abort_timeout: got no ACK expected ACK");
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0; last_rdata = 32'h0;
    rst_n = 1'b0;
    if_w2.req = 1'b0; if_w2.wr = 1'b0; if_w2.addr = 16'h0; if_w2.wdata = 32'h0; if_w2.mdata_in = 32'h0;
    if_w0.req = 1'b0; if_w0.wr = 1'b0; if_w0.addr = 16'h0; if_w0.wdata = 32'h0; if_w0.mdata_in = 32'h0;
    test_reset();
    test_read_w2();
    test_write_w2();
    test_misaligned();
    test_back_to_back_w0();
    test_reset_mid_write();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
